// File: rtl/cva6_feature_cfg_ctrl.sv
// Runtime feature-enable controller: accepts reconfiguration requests, drains the
// pipeline, applies the clamped enable vector and pulses a flush before responding.
//   IDLE  | waiting for a request, req_ready_o high
//   DRAIN | halting issue, waiting for pipeline idle or drain timeout
//   APPLY | pipeline empty, latch pending vector into feat_en
//   FLUSH | one-cycle flush pulse with new enables visible
//   RESP  | completion held until accepted
module cva6_feature_cfg_ctrl #(
  parameter int unsigned        NR_FEAT       = 8,
  parameter logic [NR_FEAT-1:0] FEAT_HW_MASK  = 8'hE1,
  parameter logic [NR_FEAT-1:0] RESET_FEAT    = 8'hC1,
  parameter int unsigned        DRAIN_TIMEOUT = 1024,
  parameter int unsigned        CNT_W         = $clog2(DRAIN_TIMEOUT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [NR_FEAT-1:0] req_feat_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [1:0]         resp_status_o,
  output logic               halt_req_o,
  input  logic               pipeline_idle_i,
  output logic               flush_o,
  output logic [NR_FEAT-1:0] feat_en_o,
  output logic               busy_o
);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_CLAMPED = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_TIMEOUT - 1);

  // Only the eight defined feature bits may ever be set; anything above is reserved.
  function automatic logic [NR_FEAT-1:0] impl_mask();
    logic [NR_FEAT-1:0] m;
    for (int i = 0; i < int'(NR_FEAT); i++) begin
      m[i] = (i < 8) ? FEAT_HW_MASK[i] : 1'b0;
    end
    return m;
  endfunction

  localparam logic [NR_FEAT-1:0] IMPL_MASK = impl_mask();

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    APPLY = 3'd2,
    FLUSH = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NR_FEAT-1:0] pend_q, pend_d;
  logic [NR_FEAT-1:0] feat_q, feat_d;
  logic               clamped_q, clamped_d;
  logic [1:0]         status_q, status_d;

  logic [NR_FEAT-1:0] req_pend;
  logic               req_clamped;

  // FP sub-formats are meaningless without the base FPU.
  always_comb begin
    req_pend = req_feat_i & IMPL_MASK;
    if (!req_pend[0]) begin
      req_pend[4:1] = 4'b0000;
    end
    req_clamped = (req_pend != req_feat_i);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    feat_d       = feat_q;
    clamped_d    = clamped_q;
    status_d     = status_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    halt_req_o   = 1'b0;
    flush_o      = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          pend_d    = req_pend;
          clamped_d = req_clamped;
          if (req_pend == feat_q) begin
            status_d = req_clamped ? ST_CLAMPED : ST_OK;
            state_d  = RESP;
          end else begin
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        halt_req_o = 1'b1;
        if (pipeline_idle_i) begin
          state_d = APPLY;
        end else if (cnt_q == CNT_MAX) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      APPLY: begin
        halt_req_o = 1'b1;
        feat_d     = pend_q;
        state_d    = FLUSH;
      end
      FLUSH: begin
        halt_req_o = 1'b1;
        flush_o    = 1'b1;
        status_d   = clamped_q ? ST_CLAMPED : ST_OK;
        state_d    = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      feat_q    <= RESET_FEAT & IMPL_MASK;
      clamped_q <= 1'b0;
      status_q  <= ST_OK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      feat_q    <= feat_d;
      clamped_q <= clamped_d;
      status_q  <= status_d;
    end
  end

  assign resp_status_o = status_q;
  assign feat_en_o     = feat_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_cva6_feature_cfg_ctrl.sv
// Self-checking bench: directed test-plan scenarios followed by random requests,
// predicted by a transaction-level model of the enable vector and response timing.
module tb_cva6_feature_cfg_ctrl;

  localparam int DT = 16;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [7:0] req_feat_i;
  logic       resp_valid_o;
  logic       resp_ready_i;
  logic [1:0] resp_status_o;
  logic       halt_req_o;
  logic       pipeline_idle_i;
  logic       flush_o;
  logic [7:0] feat_en_o;
  logic       busy_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] model_feat;

  cva6_feature_cfg_ctrl #(.DRAIN_TIMEOUT(DT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_feat_i(req_feat_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_status_o(resp_status_o),
    .halt_req_o(halt_req_o), .pipeline_idle_i(pipeline_idle_i), .flush_o(flush_o),
    .feat_en_o(feat_en_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] clamp_feat(input logic [7:0] f);
    logic [7:0] p;
    p = f & 8'hE1;
    if (p[0] == 1'b0) p = p & 8'hE1;
    return p;
  endfunction

  // Runs one request from IDLE. d = drain cycle (0-based) in which the pipeline reports
  // idle; d < 0 means never. Caller is positioned #1 after a rising edge.
  task automatic run_req(input logic [7:0] f, input int d, input int hold);
    logic [7:0] pend;
    logic [7:0] old;
    logic [1:0] exp_st;
    bit         change, tmo, done;
    int         resp_k;
    pend   = clamp_feat(f);
    old    = model_feat;
    change = (pend != old);
    tmo    = change && (d < 0 || d >= DT);
    if (!change)   resp_k = 1;
    else if (tmo)  resp_k = DT + 1;
    else           resp_k = d + 4;
    exp_st = tmo ? 2'b10 : ((pend != f) ? 2'b01 : 2'b00);

    req_valid_i     = 1'b1;
    req_feat_i      = f;
    pipeline_idle_i = 1'b0;
    check_eq("req_ready_idle", req_ready_o, 1);
    @(posedge clk_i);
    done = 0;
    for (int k = 1; k <= DT + 8; k++) begin
      #1;
      req_valid_i     = 1'b0;
      pipeline_idle_i = (d >= 0 && k >= d + 1);
      check_eq("halt", halt_req_o, (change && k < resp_k));
      check_eq("flush", flush_o, (change && !tmo && k == resp_k - 1));
      check_eq("feat", feat_en_o, (change && !tmo && k >= resp_k - 1) ? pend : old);
      check_eq("resp_valid", resp_valid_o, (k == resp_k));
      check_eq("busy", busy_o, 1);
      if (k == resp_k) begin
        check_eq("status", resp_status_o, exp_st);
        done = 1;
        break;
      end
      @(posedge clk_i);
    end
    if (!done) check_eq("resp_never_seen", 0, 1);
    if (change && !tmo) model_feat = pend;

    resp_ready_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_i); #1;
      check_eq("resp_hold_valid", resp_valid_o, 1);
      check_eq("resp_hold_status", resp_status_o, exp_st);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i    = 1'b0;
    pipeline_idle_i = 1'b0;
    check_eq("post_resp_valid", resp_valid_o, 0);
    check_eq("post_resp_ready", req_ready_o, 1);
    check_eq("post_resp_feat", feat_en_o, model_feat);
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_feat_i = 8'h00;
    resp_ready_i = 1'b0; pipeline_idle_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i      = 1'b0;
    model_feat = 8'hC1;
    check_eq("rst_feat", feat_en_o, 8'hC1);
    check_eq("rst_req_ready", req_ready_o, 1);
    check_eq("rst_halt", halt_req_o, 0);
    check_eq("rst_flush", flush_o, 0);
    check_eq("rst_resp_valid", resp_valid_o, 0);
    check_eq("rst_busy", busy_o, 0);

    run_req(8'h21, 0, 0);
    run_req(8'h1E, 0, 1);
    run_req(8'hE1, 5, 0);
    run_req(8'h01, -1, 0);
    run_req(8'hE1, DT - 1, 0);

    // Reset in the middle of a drain aborts without a response.
    req_valid_i = 1'b1; req_feat_i = 8'h01;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check_eq("mid_drain_halt", halt_req_o, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i      = 1'b0;
    model_feat = 8'hC1;
    check_eq("abort_feat", feat_en_o, 8'hC1);
    check_eq("abort_ready", req_ready_o, 1);
    check_eq("abort_halt", halt_req_o, 0);
    check_eq("abort_flush", flush_o, 0);
    check_eq("abort_resp", resp_valid_o, 0);
    repeat (3) begin
      @(posedge clk_i); #1;
      check_eq("abort_no_resp", resp_valid_o, 0);
    end

    run_req(8'hC1, 0, 3);

    for (int t = 0; t < 60; t++) begin
      logic [7:0] f;
      int d;
      f = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) f = model_feat;
      d = int'($urandom_range(0, DT + 4));
      if (d > DT) d = -1;
      run_req(f, d, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
